dispatch_q: RTL and testbench
=============================

Name: dispatch_q

Overview:
- Parametrised in-order instruction dispatch queue between the IFU and the execute pipeline; successor to the fixed two-slot decode register.
- Accepts FETCH_W-wide fetch packets and predecodes them at enqueue.
- Buffers up to DEPTH instructions.
- Issues up to ISSUE_W oldest instructions per cycle, subject to external operand readiness and intra-group hazard serialisation.

Parameters:
FETCH_W, 2, instructions per fetch packet (1..4)
ISSUE_W, 2, maximum instructions issued per cycle (1..4, <= DEPTH)
DEPTH, 8, queue entries; power of two, >= 2*FETCH_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all queued entries
stall  in  1  block issue this cycle
fe_valid  in  FETCH_W  per-slot valid of fetch packet
fe_inst  in  FETCH_W x 32  fetched instructions, slot 0 oldest
fe_addr  in  32  PC of slot 0; slot i PC = fe_addr + 4*i
fe_ready  out  1  queue can accept a full packet this cycle
iss_inst  out  ISSUE_W x 32  head instructions, slot 0 oldest
iss_pc  out  ISSUE_W x 32  PCs of head entries
iss_pd  out  ISSUE_W x predec_t  predecoded fields (rs1/rs2/rd addr + enables, lsu)
iss_ops_ready  in  ISSUE_W  operands of head slot k available (from fwd_init logic)
iss_valid  out  ISSUE_W  slot k issues this cycle
occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Storage: circular buffer with head/tail pointers (wrap mod DEPTH) and count register. Each entry holds inst, pc and predec_t.
- fe_ready = (count <= DEPTH - FETCH_W). It is computed from the registered count only; same-cycle dequeue is not credited, so there is no comb path from iss_ops_ready.
- Enqueue when fe_ready && |fe_valid && !flush.
  - Valid slots are compacted in slot order; invalid slots leave no holes.
  - Each stored pc = fe_addr + 4*i for its original slot index i.
- Head view: slot k presents entry head+k.
  - Entry-valid flag hv[k] = (k < count).
  - Outputs are driven from registers and muxes only.
- Issue rule, slot k: iss_valid[k] = !stall && !flush && hv[k] && iss_ops_ready[k] && iss_valid[k-1] (k>0) && no conflict with any j<k.
  - Conflict: j modifies rd (rd_en && rd != 0) and k reads that register (rs1_en/rs2_en address match), or both j and k are lsu.
- Dequeue count n = popcount(iss_valid), always a contiguous prefix. head += n.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - n.
- Flush has priority over enqueue, dequeue and stall: count = 0, head = tail; the packet offered that cycle is dropped.
- Stall: iss_valid = 0 and no dequeue; enqueue continues while fe_ready.
- Empty queue: iss_valid = 0; no same-cycle bypass (minimum latency fetch -> issue = 1 cycle).
- Full queue (count > DEPTH-FETCH_W): fe_ready = 0; the IFU must hold its packet.
- Reset (also mid-operation): count = 0, head = tail = 0, fe_ready = 1, iss_valid = 0, occupancy = 0. Entry payloads are not reset.
- x0 destination never creates a conflict.

Optional Feature:
- Macro DISPQ_SINGLE_ISSUE_EN.
- Defined: iss_valid[k] = 0 for all k >= 1; at most one instruction issues per cycle (serialised debug mode).
- Undefined: full ISSUE_W issue as specified above.
- fe_ready and storage are unaffected either way.

Decomposition:
- srv_defs gains:
  - predec_t: rs1_en, rs2_en, rd_en, lsu, rs1, rs2, rd
  - dispq_entry_t: inst, pc, pd
  - constant ILEN = 32
- Sub-module inst_predec: combinational, 32-bit inst -> predec_t. Instantiated FETCH_W times at the enqueue side.
- The hazard prefix logic stays inline as a generate loop.

Test Plan:
- Defaults; push packet addr 0x100 {addi x1,x0,1 ; addi x2,x0,2}, all ops_ready=1 -> next cycle iss_valid=2'b11, iss_pc={0x100,0x104}, occupancy returns to 0.
- Push {addi x1,x0,1 ; add x3,x1,x1} -> cycle 1 iss_valid=2'b01; cycle 2 iss_valid=2'b01 with pc 0x104. Repeat with rd=x0 in slot 0 -> 2'b11.
- Push {lw x5,0(x2) ; sw x6,4(x2)} -> lw and sw issue in separate cycles.
- fe_valid=2'b10 at addr 0x200 -> single entry, iss_pc[0]=0x204.
- Fill with ops_ready=0 and stall=1 until occupancy=8 -> fe_ready=0 at occupancy 7. Then flush with a packet offered -> occupancy=0, fe_ready=1, packet dropped.
- Wrap: push 5 packets while issuing 2/cycle -> pointer wrap past entry 7, in-order PCs. With DISPQ_SINGLE_ISSUE_EN, same stimulus -> never more than one iss_valid bit set.

Source files
------------

// File: rtl/dispatch_q_pkg.sv
// Shared types for the dispatch queue: predecoded operand fields, queue entry
// layout, RISC-V major opcodes and the pairwise issue-hazard helper.
package dispatch_q_pkg;

    localparam int ILEN = 32;

    typedef struct packed {
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_en;
        logic       lsu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } predec_t;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [31:0]     pc;
        predec_t         pd;
    } dispq_entry_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    // An older instruction blocks a younger one in the same issue group when it
    // writes a register the younger reads (x0 excluded), or both touch memory.
    function automatic logic pd_hazard(input predec_t older, input predec_t younger);
        logic wr_s;
        logic raw_s;
        wr_s  = older.rd_en && (older.rd != 5'd0);
        raw_s = (younger.rs1_en && (younger.rs1 == older.rd)) ||
                (younger.rs2_en && (younger.rs2 == older.rd));
        return (wr_s && raw_s) || (older.lsu && younger.lsu);
    endfunction

endpackage

// File: rtl/dispatch_q_if.sv
// Fetch-side and issue-side handshake bundle of the dispatch queue.
// master = IFU / execute side, slave = the queue itself.
interface dispatch_q_if #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
);
    import dispatch_q_pkg::*;

    logic                          flush;
    logic                          stall;
    logic [FETCH_W-1:0]            fe_valid;
    logic [FETCH_W-1:0][ILEN-1:0]  fe_inst;
    logic [31:0]                   fe_addr;
    logic                          fe_ready;
    logic [ISSUE_W-1:0][ILEN-1:0]  iss_inst;
    logic [ISSUE_W-1:0][31:0]      iss_pc;
    predec_t [ISSUE_W-1:0]         iss_pd;
    logic [ISSUE_W-1:0]            iss_ops_ready;
    logic [ISSUE_W-1:0]            iss_valid;
    logic [$clog2(DEPTH):0]        occupancy;

    modport master (
        output flush, stall, fe_valid, fe_inst, fe_addr, iss_ops_ready,
        input  fe_ready, iss_inst, iss_pc, iss_pd, iss_valid, occupancy
    );

    modport slave (
        input  flush, stall, fe_valid, fe_inst, fe_addr, iss_ops_ready,
        output fe_ready, iss_inst, iss_pc, iss_pd, iss_valid, occupancy
    );

endinterface

// File: rtl/dispatch_q_inst_predec.sv
// Combinational RV32 predecoder: extracts register addresses, their use
// enables and the load/store flag from one instruction word.
module inst_predec
    import dispatch_q_pkg::*;
(
    input  logic [ILEN-1:0] inst,
    output predec_t         pd
);

    logic [6:0] opc_s;
    logic       unused_s;

    assign opc_s    = inst[6:0];
    assign unused_s = ^{inst[31:25], inst[14:12]};

    // Field extraction is unconditional; only the enables depend on opcode.
    always_comb begin
        pd     = '0;
        pd.rs1 = inst[19:15];
        pd.rs2 = inst[24:20];
        pd.rd  = inst[11:7];
        case (opc_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                pd.rd_en = 1'b1;
            end
            OPC_JALR, OPC_IMM: begin
                pd.rd_en  = 1'b1;
                pd.rs1_en = 1'b1;
            end
            OPC_BRANCH: begin
                pd.rs1_en = 1'b1;
                pd.rs2_en = 1'b1;
            end
            OPC_LOAD: begin
                pd.rd_en  = 1'b1;
                pd.rs1_en = 1'b1;
                pd.lsu    = 1'b1;
            end
            OPC_STORE: begin
                pd.rs1_en = 1'b1;
                pd.rs2_en = 1'b1;
                pd.lsu    = 1'b1;
            end
            OPC_REG: begin
                pd.rd_en  = 1'b1;
                pd.rs1_en = 1'b1;
                pd.rs2_en = 1'b1;
            end
            default: begin
                pd.rd_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dispatch_q.sv
// In-order dispatch queue: predecodes FETCH_W-wide packets at enqueue and
// issues up to ISSUE_W hazard-free head entries per cycle.
// Optional macro DISPQ_SINGLE_ISSUE_EN restricts issue to slot 0 only.
module dispatch_q
    import dispatch_q_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    dispatch_q_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_W);

    dispq_entry_t                  mem_r [DEPTH];
    logic [PTR_W-1:0]              head_r;
    logic [PTR_W-1:0]              tail_r;
    logic [CNT_W-1:0]              count_r;

    predec_t                       fe_pd_s  [FETCH_W];
    logic [FETCH_W-1:0][PTR_W-1:0] wr_off_s;
    logic [CNT_W-1:0]              enq_n_s;
    logic [CNT_W-1:0]              deq_n_s;
    logic                          enq_s;
    logic                          fe_ready_s;
    logic                          iss_ok_s;

    dispq_entry_t                  head_s [ISSUE_W];
    logic [ISSUE_W-1:0]            hv_s;
    logic [ISSUE_W-1:0]            conf_s;
    logic [ISSUE_W-1:0]            iv_s;

    for (genvar i = 0; i < FETCH_W; i++) begin : g_pd
        inst_predec u_predec (
            .inst (bus.fe_inst[i]),
            .pd   (fe_pd_s[i])
        );
    end

    // Dequeue in the same cycle is deliberately not credited here.
    assign fe_ready_s = (count_r <= READY_MAX);
    assign enq_s      = fe_ready_s && (|bus.fe_valid) && !bus.flush;

    // Compaction: each valid slot lands at tail + (number of valid slots before it).
    always_comb begin
        enq_n_s  = '0;
        wr_off_s = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            wr_off_s[i] = enq_n_s[PTR_W-1:0];
            enq_n_s     = enq_n_s + CNT_W'(bus.fe_valid[i]);
        end
    end

    // Entry payload storage; intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (enq_s && bus.fe_valid[i]) begin
                mem_r[tail_r + wr_off_s[i]] <= '{inst: bus.fe_inst[i],
                                                 pc:   bus.fe_addr + 32'(4 * i),
                                                 pd:   fe_pd_s[i]};
            end
        end
    end

    // Head window: slot k views entry head+k, valid while k < count.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            head_s[k] = mem_r[head_r + PTR_W'(k)];
            hv_s[k]   = (CNT_W'(k) < count_r);
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_haz
        logic [ISSUE_W-1:0] pair_s;
        for (genvar j = 0; j < ISSUE_W; j++) begin : g_pair
            if (j < k) begin : g_chk
                assign pair_s[j] = pd_hazard(head_s[j].pd, head_s[k].pd);
            end else begin : g_none
                assign pair_s[j] = 1'b0;
            end
        end
        assign conf_s[k] = |pair_s;
    end

    // Issue prefix: a slot goes only if every older slot in the group went.
    always_comb begin
        iss_ok_s = !bus.stall && !bus.flush;
        deq_n_s  = '0;
        iv_s     = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            iss_ok_s = iss_ok_s && hv_s[k] && bus.iss_ops_ready[k] && !conf_s[k];
`ifdef DISPQ_SINGLE_ISSUE_EN
            iv_s[k]  = iss_ok_s && (k == 0);
`else
            iv_s[k]  = iss_ok_s;
`endif
            deq_n_s  = deq_n_s + CNT_W'(iv_s[k]);
        end
    end

    // Pointer and count update; flush discards everything including the offered packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (bus.flush) begin
            head_r  <= tail_r;
            count_r <= '0;
        end else begin
            head_r  <= head_r + deq_n_s[PTR_W-1:0];
            if (enq_s) begin
                tail_r <= tail_r + enq_n_s[PTR_W-1:0];
            end
            count_r <= count_r + (enq_s ? enq_n_s : '0) - deq_n_s;
        end
    end

    // Issue-side outputs are plain muxes over stored entries.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            bus.iss_inst[k] = head_s[k].inst;
            bus.iss_pc[k]   = head_s[k].pc;
            bus.iss_pd[k]   = head_s[k].pd;
        end
    end

    assign bus.iss_valid = iv_s;
    assign bus.fe_ready  = fe_ready_s;
    assign bus.occupancy = count_r;

endmodule

// File: tb/tb_dispatch_q.sv
// Scoreboard bench for dispatch_q (default 2-wide fetch/issue, depth 8);
// honours DISPQ_SINGLE_ISSUE_EN for the expected issue patterns.
module tb_dispatch_q;

    localparam int FW = 2;
    localparam int IW = 2;
    localparam int D  = 8;
`ifdef DISPQ_SINGLE_ISSUE_EN
    localparam logic [1:0] PAIR = 2'b01;
`else
    localparam logic [1:0] PAIR = 2'b11;
`endif

    localparam logic [31:0] ADDI_X1      = 32'h00100093;
    localparam logic [31:0] ADDI_X2      = 32'h00200113;
    localparam logic [31:0] ADD_X3_X1_X1 = 32'h001081B3;
    localparam logic [31:0] ADDI_X0      = 32'h00100013;
    localparam logic [31:0] ADD_X3_X0_X0 = 32'h000001B3;
    localparam logic [31:0] ADD_X4_X0_X1 = 32'h00100233;
    localparam logic [31:0] LW_X5        = 32'h00012283;
    localparam logic [31:0] SW_X6        = 32'h00612223;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   occ_m = 0;
    logic [1:0]  last_iv;
    logic [31:0] last_pc0;
    bit   last_acc;
    exp_t sb[$];

    dispatch_q_if #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D)) bus ();

    dispatch_q #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_addi(input int rd, input int imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h00000013;
    endfunction

    task automatic offer(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] addr);
        bus.fe_valid   = fv;
        bus.fe_inst[0] = i0;
        bus.fe_inst[1] = i1;
        bus.fe_addr    = addr;
    endtask

    // One clock: check outputs on the falling edge, update the model, advance.
    task automatic step();
        logic [1:0] iv;
        logic [1:0] pfx;
        int         n_enq;
        exp_t       e;
        n_enq = 0;
        @(negedge clk);
        iv = bus.iss_valid;
        check("occupancy", 32'(bus.occupancy), 32'(occ_m));
        check("fe_ready", 32'(bus.fe_ready), 32'(occ_m <= D - FW));
        pfx = iv & (iv + 2'b01);
        check("iv_prefix", 32'(pfx), 32'd0);
        if (bus.flush || bus.stall || occ_m == 0) check("iv_idle", 32'(iv), 32'd0);
`ifdef DISPQ_SINGLE_ISSUE_EN
        check("single_issue", 32'(iv[1]), 32'd0);
`endif
        for (int k = 0; k < IW; k++) begin
            if (iv[k]) begin
                if (sb.size() == 0) begin
                    check("spurious_issue", 32'(iv[k]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("iss_pc", bus.iss_pc[k], e.pc);
                    check("iss_inst", bus.iss_inst[k], e.inst);
                end
            end
        end
        last_acc = 1'b0;
        if (!bus.flush && bus.fe_valid != 2'b00 && occ_m <= D - FW) begin
            last_acc = 1'b1;
            for (int i = 0; i < FW; i++) begin
                if (bus.fe_valid[i]) begin
                    e.pc   = bus.fe_addr + 32'(4 * i);
                    e.inst = bus.fe_inst[i];
                    sb.push_back(e);
                    n_enq++;
                end
            end
        end
        if (bus.flush) begin
            sb.delete();
            occ_m = 0;
        end else begin
            occ_m = occ_m + n_enq - $countones(iv);
        end
        last_iv  = iv;
        last_pc0 = bus.iss_pc[0];
        @(posedge clk);
        #1;
        if (last_acc || bus.flush) bus.fe_valid = 2'b00;
        bus.flush = 1'b0;
    endtask

    task automatic push_pkt(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] addr);
        offer(fv, i0, i1, addr);
        for (int c = 0; c < 40; c++) begin
            step();
            if (last_acc) break;
        end
        check("push_accepted", 32'(last_acc), 32'd1);
        bus.fe_valid = 2'b00;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && occ_m != 0; c++) step();
        check("drain_occupancy", 32'(bus.occupancy), 32'd0);
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fe_valid = 2'b00;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        occ_m = 0;
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_fe_ready", 32'(bus.fe_ready), 32'd1);
        check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bus.fe_valid = 2'b00;
        bus.fe_inst = '0;
        bus.fe_addr = 32'd0;
        bus.iss_ops_ready = 2'b11;
        do_reset();

        // Independent pair issues together one cycle after enqueue.
        push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h100);
        step();
        check("t1_iv", 32'(last_iv), 32'(PAIR));
        drain();

        // RAW via rs1/rs2 serialises; x0 destination does not.
        push_pkt(2'b11, ADDI_X1, ADD_X3_X1_X1, 32'h300);
        step(); check("raw_rs1_c1", 32'(last_iv), 32'd1);
        step(); check("raw_rs1_c2", 32'(last_iv), 32'd1);
        check("raw_rs1_pc", last_pc0, 32'h304);
        drain();
        push_pkt(2'b11, ADDI_X0, ADD_X3_X0_X0, 32'h340);
        step(); check("x0_iv", 32'(last_iv), 32'(PAIR));
        drain();
        push_pkt(2'b11, ADDI_X1, ADD_X4_X0_X1, 32'h380);
        step(); check("raw_rs2_c1", 32'(last_iv), 32'd1);
        step(); check("raw_rs2_c2", 32'(last_iv), 32'd1);
        drain();

        // Two memory ops never share an issue group.
        push_pkt(2'b11, LW_X5, SW_X6, 32'h3c0);
        step(); check("lsu_c1", 32'(last_iv), 32'd1);
        step(); check("lsu_c2", 32'(last_iv), 32'd1);
        drain();

        // Only slot 1 valid: compacted into one entry with pc = addr + 4.
        push_pkt(2'b10, 32'hDEADBEEF, ADDI_X2, 32'h200);
        step(); check("compact_iv", 32'(last_iv), 32'd1);
        check("compact_pc", last_pc0, 32'h204);
        drain();

        // Reset in the middle of operation empties the queue.
        bus.stall = 1'b1;
        push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h600);
        step();
        bus.stall = 1'b0;
        do_reset();

        // Fill to 7 with issue blocked, hold a packet, then flush it away.
        bus.stall = 1'b1;
        bus.iss_ops_ready = 2'b00;
        push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h400);
        push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h408);
        push_pkt(2'b01, ADDI_X1, ADDI_X2, 32'h410);
        push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h418);
        check("occ7", 32'(bus.occupancy), 32'd7);
        check("occ7_fe_ready", 32'(bus.fe_ready), 32'd0);
        offer(2'b11, ADDI_X1, ADDI_X2, 32'h420);
        step();
        step();
        bus.flush = 1'b1;
        step();
        check("flush_occupancy", 32'(bus.occupancy), 32'd0);
        check("flush_fe_ready", 32'(bus.fe_ready), 32'd1);
        for (int p = 0; p < 4; p++) push_pkt(2'b11, ADDI_X1, ADDI_X2, 32'h440 + 32'(8 * p));
        check("occ8", 32'(bus.occupancy), 32'd8);
        check("occ8_fe_ready", 32'(bus.fe_ready), 32'd0);
        bus.flush = 1'b1;
        offer(2'b11, ADDI_X1, ADDI_X2, 32'h460);
        step();
        bus.stall = 1'b0;
        bus.iss_ops_ready = 2'b11;
        step();
        check("flush_drop_iv", 32'(last_iv), 32'd0);
        check("flush_drop_occ", 32'(bus.occupancy), 32'd0);

        // Back-to-back packets across the pointer wrap.
        for (int p = 0; p < 5; p++) begin
            push_pkt(2'b11, mk_addi(2 * p + 1, p), mk_addi(2 * p + 2, p), 32'h500 + 32'(8 * p));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
